// File: rtl/iomem_timer_pkg.sv
// rtl/iomem_timer_pkg.sv - register map and field indices for the iomem timer
package iomem_timer_pkg;

   localparam logic [7:0] OFS_CTRL    = 8'h00;
   localparam logic [7:0] OFS_PRESC   = 8'h04;
   localparam logic [7:0] OFS_COMPARE = 8'h08;
   localparam logic [7:0] OFS_COUNT   = 8'h0C;
   localparam logic [7:0] OFS_STATUS  = 8'h10;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_IRQ_EN   = 2;

   localparam int STATUS_MATCH  = 0;

   // Replace only the byte lanes selected by the write strobes.
   function automatic logic [31:0] merge_bytes(input logic [31:0] i_old,
                                               input logic [31:0] i_wdata,
                                               input logic [3:0]  i_wstrb);
      logic [31:0] w_out;
      w_out = i_old;
      for (int n = 0; n < 4; n++) begin
         if (i_wstrb[n]) w_out[8*n +: 8] = i_wdata[8*n +: 8];
      end
      return w_out;
   endfunction

endpackage

// File: rtl/iomem_timer_presc.sv
// rtl/iomem_timer_presc.sv - prescale counter producing a tick every PRESC+1 enabled cycles
module iomem_timer_presc
   import iomem_timer_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_en,
   input  logic [31:0] i_presc,
   input  logic        i_clr,
   output logic        o_tick
);

   logic [31:0] r_pcnt;

   assign o_tick = i_en & (r_pcnt == i_presc);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pcnt <= '0;
      end else if (!i_en || i_clr || o_tick) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + 32'd1;
      end
   end

endmodule

// File: rtl/iomem_timer.sv
// rtl/iomem_timer.sv - iomem-mapped timer/compare peripheral with level interrupt
module iomem_timer
   import iomem_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
   parameter logic [31:0] PRESC_RESET = 32'd0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        irq
);

   logic        r_ready;
   logic [31:0] r_rdata;
   logic        r_en, r_periodic, r_irq_en, r_match;
   logic [31:0] r_presc, r_compare, r_count;

   logic        w_sel, w_commit, w_wr;
   logic        w_wr_ctrl, w_wr_presc, w_wr_compare, w_wr_count, w_w1c;
   logic        w_tick, w_hit_cmp, w_clr;
   logic [7:0]  w_ofs;
   logic [31:0] w_rd_val;

   assign w_sel    = iomem_valid & (iomem_addr[31:8] == BASE_ADDR[31:8]);
   // Access commits on the edge that raises ready; the held valid is ignored the cycle after.
   assign w_commit = w_sel & ~r_ready;
   assign w_wr     = w_commit & (|iomem_wstrb);
   assign w_ofs    = iomem_addr[7:0];

   assign w_wr_ctrl    = w_wr & (w_ofs == OFS_CTRL) & iomem_wstrb[0];
   assign w_wr_presc   = w_wr & (w_ofs == OFS_PRESC);
   assign w_wr_compare = w_wr & (w_ofs == OFS_COMPARE);
   assign w_wr_count   = w_wr & (w_ofs == OFS_COUNT);
   assign w_w1c        = w_wr & (w_ofs == OFS_STATUS) & iomem_wstrb[0] & iomem_wdata[STATUS_MATCH];

   assign w_hit_cmp = w_tick & (r_count == r_compare);
   assign w_clr     = w_wr_count | (w_wr_ctrl & iomem_wdata[CTRL_EN] & ~r_en);

   iomem_timer_presc u_presc (
      .clk     (clk),
      .resetn  (resetn),
      .i_en    (r_en),
      .i_presc (r_presc),
      .i_clr   (w_clr),
      .o_tick  (w_tick)
   );

   always_comb begin
      w_rd_val = '0;
      case (w_ofs)
         OFS_CTRL: begin
            w_rd_val[CTRL_EN]       = r_en;
            w_rd_val[CTRL_PERIODIC] = r_periodic;
            w_rd_val[CTRL_IRQ_EN]   = r_irq_en;
         end
         OFS_PRESC:   w_rd_val = r_presc;
         OFS_COMPARE: w_rd_val = r_compare;
         OFS_COUNT:   w_rd_val = r_count;
         OFS_STATUS:  w_rd_val[STATUS_MATCH] = r_match;
         default:     w_rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ready    <= 1'b0;
         r_rdata    <= '0;
         r_en       <= 1'b0;
         r_periodic <= 1'b0;
         r_irq_en   <= 1'b0;
         r_match    <= 1'b0;
         r_presc    <= PRESC_RESET;
         r_compare  <= 32'hFFFF_FFFF;
         r_count    <= '0;
      end else begin
         r_ready <= w_commit;
         if (w_commit) r_rdata <= w_rd_val;

         // A bus write to CTRL overrides the one-shot auto-disable.
         if (w_wr_ctrl) begin
            r_en       <= iomem_wdata[CTRL_EN];
            r_periodic <= iomem_wdata[CTRL_PERIODIC];
            r_irq_en   <= iomem_wdata[CTRL_IRQ_EN];
         end else if (w_hit_cmp && !r_periodic) begin
            r_en <= 1'b0;
         end

         if (w_wr_presc)   r_presc   <= merge_bytes(r_presc, iomem_wdata, iomem_wstrb);
         if (w_wr_compare) r_compare <= merge_bytes(r_compare, iomem_wdata, iomem_wstrb);

         if (w_wr_count) begin
            r_count <= merge_bytes(r_count, iomem_wdata, iomem_wstrb);
         end else if (w_tick) begin
            if (!w_hit_cmp)     r_count <= r_count + 32'd1;
            else if (r_periodic) r_count <= '0;
         end

         if (w_hit_cmp)  r_match <= 1'b1;
         else if (w_w1c) r_match <= 1'b0;
      end
   end

   assign iomem_ready = r_ready;
   assign iomem_rdata = r_rdata;
   assign irq         = r_match & r_irq_en;

endmodule

// File: tb/tb_iomem_timer.sv
// tb/tb_iomem_timer.sv - randomized and directed checks of iomem_timer against a cycle reference model
module tb_iomem_timer;

   localparam logic [31:0] BASE      = 32'h0300_0000;
   localparam logic [31:0] PRESC_RST = 32'd0;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        iomem_valid = 1'b0;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb = 4'h0;
   logic [31:0] iomem_addr = 32'h0;
   logic [31:0] iomem_wdata = 32'h0;
   logic [31:0] iomem_rdata;
   logic        irq;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   iomem_timer #(.BASE_ADDR(BASE), .PRESC_RESET(PRESC_RST)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .irq         (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // Reference model: timer state as plain numbers, advanced once per clock.
   bit        m_en = 0, m_per = 0, m_ie = 0, m_match = 0, m_ready = 0;
   bit [31:0] m_presc = PRESC_RST, m_compare = 32'hFFFF_FFFF, m_count = 0, m_pcnt = 0, m_rdata = 0;

   function automatic bit [31:0] lanes(input bit [31:0] old, input bit [31:0] wd, input bit [3:0] s);
      bit [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (old & ~mask) | (wd & mask);
   endfunction

   always @(posedge clk or negedge resetn) begin : model
      bit hit, commit, tick, hw_set, n_en, n_match;
      bit [31:0] n_count, n_pcnt;
      if (!resetn) begin
         m_en = 0; m_per = 0; m_ie = 0; m_match = 0; m_ready = 0;
         m_presc = PRESC_RST; m_compare = 32'hFFFF_FFFF; m_count = 0; m_pcnt = 0; m_rdata = 0;
      end else begin
         hit    = iomem_valid && (iomem_addr[31:8] == BASE[31:8]);
         commit = hit && !m_ready;
         tick   = m_en && (m_pcnt == m_presc);
         hw_set = tick && (m_count == m_compare);
         n_en = m_en;
         n_match = m_match || hw_set;
         n_count = m_count;
         if (tick) begin
            if (!hw_set)    n_count = m_count + 1;
            else if (m_per) n_count = 0;
            else            n_en = 0;
         end
         n_pcnt = (m_en && !tick) ? m_pcnt + 1 : 32'd0;
         if (commit) begin
            case (iomem_addr[7:0])
               8'h00:   m_rdata = {29'd0, m_ie, m_per, m_en};
               8'h04:   m_rdata = m_presc;
               8'h08:   m_rdata = m_compare;
               8'h0C:   m_rdata = m_count;
               8'h10:   m_rdata = {31'd0, m_match};
               default: m_rdata = 0;
            endcase
            if (iomem_wstrb != 0) begin
               case (iomem_addr[7:0])
                  8'h00: if (iomem_wstrb[0]) begin
                     if (iomem_wdata[0] && !m_en) n_pcnt = 0;
                     n_en = iomem_wdata[0]; m_per = iomem_wdata[1]; m_ie = iomem_wdata[2];
                  end
                  8'h04: m_presc = lanes(m_presc, iomem_wdata, iomem_wstrb);
                  8'h08: m_compare = lanes(m_compare, iomem_wdata, iomem_wstrb);
                  8'h0C: begin n_count = lanes(m_count, iomem_wdata, iomem_wstrb); n_pcnt = 0; end
                  8'h10: if (iomem_wstrb[0] && iomem_wdata[0] && !hw_set) n_match = 0;
                  default: ;
               endcase
            end
         end
         m_ready = commit;
         m_en = n_en; m_match = n_match; m_count = n_count; m_pcnt = n_pcnt;
      end
   end

   always @(negedge clk) begin
      if (resetn) begin
         check_val("ready", iomem_ready, m_ready);
         check_val("irq", irq, m_ie & m_match);
         check_val("rdata", iomem_rdata, m_rdata);
      end
   end

   task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                      output logic [31:0] rdv);
      int n;
      iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = wd;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!iomem_ready && n < 8);
      check_val("ack_latency", n, 1);
      rdv = iomem_rdata;
      iomem_valid = 1'b0; iomem_wstrb = 4'h0;
      @(posedge clk); #1;
   endtask

   task automatic wr_s(input logic [7:0] ofs, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      bus(BASE | {24'd0, ofs}, s, d, dummy);
   endtask

   task automatic wr(input logic [7:0] ofs, input logic [31:0] d);
      wr_s(ofs, d, 4'hF);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] ofs, input logic [31:0] exp);
      logic [31:0] v;
      bus(BASE | {24'd0, ofs}, 4'h0, 32'h0, v);
      check_val(tag, v, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_irq(input string tag, input int limit);
      int n;
      n = 0;
      while (irq !== 1'b1 && n < limit) begin @(posedge clk); #1; n++; end
      check_val(tag, irq, 1);
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int acks, c0, op;
      logic [31:0] v;

      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;

      check_val("rst_ready", iomem_ready, 0);
      check_val("rst_irq", irq, 0);
      rd_chk("rst_ctrl", 8'h00, 0);
      rd_chk("rst_presc", 8'h04, PRESC_RST);
      rd_chk("rst_compare", 8'h08, 32'hFFFF_FFFF);
      rd_chk("rst_count", 8'h0C, 0);
      rd_chk("rst_status", 8'h10, 0);

      // Held valid: ready pulses on the first edge, drops on the next.
      iomem_valid = 1'b1; iomem_addr = BASE + 32'h4; iomem_wstrb = 4'hF; iomem_wdata = 32'd5;
      @(posedge clk); #1; check_val("hs_ready_c1", iomem_ready, 1);
      @(posedge clk); #1; check_val("hs_ready_c2", iomem_ready, 0);
      iomem_valid = 1'b0; iomem_wstrb = 4'h0;
      idle(1);
      rd_chk("hs_readback", 8'h04, 5);

      iomem_valid = 1'b1; iomem_addr = 32'h0400_0004; iomem_wstrb = 4'hF; iomem_wdata = 32'd7;
      acks = 0;
      repeat (4) begin @(posedge clk); #1; if (iomem_ready) acks++; end
      iomem_valid = 1'b0; iomem_wstrb = 4'h0;
      check_val("outside_no_ack", acks, 0);
      idle(1);
      rd_chk("outside_no_effect", 8'h04, 5);

      wr(8'h08, 32'h0);
      wr_s(8'h08, 32'hAABB_CCDD, 4'b0101);
      rd_chk("byte_lanes", 8'h08, 32'h00BB_00DD);
      wr(8'h20, 32'h1234_5678);
      rd_chk("unmapped_read", 8'h20, 0);

      wr(8'h00, 0); wr(8'h10, 1);
      wr(8'h04, 2); wr(8'h08, 3); wr(8'h0C, 0); wr(8'h00, 3'b111);
      wait_irq("periodic_irq1", 40);
      c0 = cyc;
      rd_chk("periodic_wrap", 8'h0C, 0);
      wr(8'h10, 1);
      check_val("w1c_irq_drop", irq, 0);
      wait_irq("periodic_irq2", 40);
      check_val("periodic_period", cyc - c0, 12);
      wr(8'h00, 0);

      wr(8'h10, 1); wr(8'h04, 0); wr(8'h08, 2); wr(8'h0C, 0); wr(8'h00, 3'b001);
      idle(8);
      rd_chk("oneshot_en_cleared", 8'h00, 0);
      rd_chk("oneshot_count", 8'h0C, 2);
      rd_chk("oneshot_match", 8'h10, 1);
      check_val("oneshot_no_irq", irq, 0);

      // Back-to-back accesses commit two edges apart; with PRESC=1 they land on ticks.
      wr(8'h10, 1); wr(8'h04, 1); wr(8'h08, 5); wr(8'h0C, 5);
      wr(8'h00, 3'b111);
      wr(8'h10, 1);
      wr(8'h0C, 10);
      rd_chk("count_write_wins", 8'h0C, 10);
      rd_chk("set_beats_w1c", 8'h10, 1);
      check_val("collision_irq", irq, 1);
      wr(8'h00, 0);

      for (int i = 0; i < 160; i++) begin
         op = $urandom_range(0, 7);
         case (op)
            0: wr(8'h00, $urandom_range(0, 7));
            1: wr(8'h04, $urandom_range(0, 3));
            2: wr_s(8'h08, $urandom_range(0, 10), 4'($urandom_range(0, 15)));
            3: wr(8'h0C, $urandom_range(0, 10));
            4: wr(8'h10, $urandom_range(0, 1));
            5, 6: bus(BASE | ($urandom_range(0, 6) * 4), 4'h0, 32'h0, v);
            default: idle($urandom_range(1, 6));
         endcase
      end

      wr(8'h00, 0); wr(8'h04, 0); wr(8'h08, 0); wr(8'h0C, 0); wr(8'h00, 3'b111);
      idle(3);
      check_val("pre_reset_irq", irq, 1);
      iomem_valid = 1'b1; iomem_addr = BASE + 32'hC; iomem_wstrb = 4'h0;
      @(posedge clk); #1;
      check_val("pre_reset_ready", iomem_ready, 1);
      #2 resetn = 1'b0;
      #1;
      check_val("async_rst_irq", irq, 0);
      check_val("async_rst_ready", iomem_ready, 0);
      check_val("async_rst_rdata", iomem_rdata, 0);
      iomem_valid = 1'b0;
      @(posedge clk); #1 resetn = 1'b1;
      rd_chk("post_rst_count", 8'h0C, 0);
      rd_chk("post_rst_ctrl", 8'h00, 0);
      rd_chk("post_rst_compare", 8'h08, 32'hFFFF_FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
